// File: rtl/s_ram_dp.sv
// Simple dual-port synchronous RAM: byte-enabled write port, pipelined read port,
// selectable same-address collision behaviour and an optional post-reset zero-fill.
module s_ram_dp #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int RD_LAT       = 1,
  parameter int RW_MODE      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_clr_wr;
  logic              w_coll;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [NB-1:0]     w_mem_be;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_acc = w_run & wr_en & ~rst;
  assign w_rd_acc = w_run & rd_en & ~rst;
  assign w_clr_wr = ~w_run & ~rst;

  // The clear sequencer borrows the write port; user writes are dropped meanwhile.
  assign w_mem_addr = w_clr_wr ? r_cnt : wr_addr;
  assign w_mem_be   = w_clr_wr ? {NB{1'b1}} : (w_wr_acc ? wr_be : {NB{1'b0}});
  assign w_mem_data = w_clr_wr ? {DATA_W{1'b0}} : wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      r_cnt   <= '0;
    end else if (!w_run) begin
      r_cnt <= r_cnt + ADDR_W'(1);
      if (&r_cnt) begin
        r_state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_mem_be[b]) begin
        r_mem[w_mem_addr][b*8 +: 8] <= w_mem_data[b*8 +: 8];
      end
    end
  end

  // Write-first bypass: fresh bytes replace stale ones only on an address match.
  assign w_old  = r_mem[rd_addr];
  assign w_coll = w_wr_acc & (wr_addr == rd_addr);

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_merge
      assign w_merged[gi*8 +: 8] = (w_coll && wr_be[gi]) ? wr_data[gi*8 +: 8]
                                                          : w_old[gi*8 +: 8];
    end
  endgenerate

  assign w_rd_word = (RW_MODE == 1) ? w_merged : w_old;

  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] r_s2_data;
      logic              r_s2_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_data  <= '0;
          r_s2_valid <= 1'b0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rd_data  = r_s2_data;
      assign rd_valid = r_s2_valid;
    end else begin : g_lat1
      assign rd_data  = r_s1_data;
      assign rd_valid = r_s1_valid;
    end
  endgenerate

  assign busy = ~w_run;

endmodule

// File: tb/tb_s_ram_dp.sv
// Directed bench for s_ram_dp: three instances (read-first, write-first, two-cycle
// latency) share one stimulus stream and are checked against hand-computed values.
module tb_s_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [15:0] rd_data_a, rd_data_b, rd_data_c;
  logic        rd_valid_a, rd_valid_b, rd_valid_c;
  logic        busy_a, busy_b, busy_c;

  s_ram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RW_MODE(0), .CLEAR_ON_RST(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a));

  s_ram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RW_MODE(1), .CLEAR_ON_RST(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b));

  s_ram_dp #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RW_MODE(0), .CLEAR_ON_RST(1)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_c), .rd_valid(rd_valid_c), .busy(busy_c));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [15:0] wd, logic [1:0] be,
                              logic re, logic [3:0] ra, logic ev,
                              logic [15:0] ea, logic [15:0] eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.re = re; v.ra = ra; v.ev = ev; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_be   = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
  endtask

  initial begin
    int n;
    logic        pv;
    logic [15:0] pd;

    // Vector table: reads of the freshly cleared array, then functional rows.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = mk(1'b0, 4'h0, 16'h0, 2'b00, 1'b1, 4'(i), 1'b1, 16'h0000, 16'h0000);
    end
    tbl[16] = mk(1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000);
    tbl[17] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 16'hA5C3, 16'hA5C3);
    tbl[18] = mk(1'b1, 4'd5, 16'h1234, 2'b11, 1'b0, 4'd0, 1'b0, 16'hA5C3, 16'hA5C3);
    tbl[19] = mk(1'b1, 4'd5, 16'hFFEE, 2'b01, 1'b0, 4'd0, 1'b0, 16'hA5C3, 16'hA5C3);
    tbl[20] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 16'h12EE, 16'h12EE);
    tbl[21] = mk(1'b1, 4'd7, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0, 16'h12EE, 16'h12EE);
    tbl[22] = mk(1'b1, 4'd7, 16'h2222, 2'b11, 1'b1, 4'd7, 1'b1, 16'h1111, 16'h2222);
    tbl[23] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b1, 16'h2222, 16'h2222);
    tbl[24] = mk(1'b1, 4'd7, 16'hABCD, 2'b10, 1'b1, 4'd7, 1'b1, 16'h2222, 16'hAB22);
    tbl[25] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd7, 1'b1, 16'hAB22, 16'hAB22);
    tbl[26] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'hAB22, 16'hAB22);
    tbl[27] = mk(1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b0, 4'd0, 1'b0, 16'hAB22, 16'hAB22);
    tbl[28] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 16'h12EE, 16'h12EE);
    tbl[29] = mk(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 16'h12EE, 16'h12EE);

    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_rd_data_a", 32'(rd_data_a), 32'h0);
    check("rst_rd_valid_a", 32'(rd_valid_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h1);
    check("rst_rd_data_c", 32'(rd_data_c), 32'h0);
    check("rst_rd_valid_c", 32'(rd_valid_c), 32'h0);
    check("rst_busy_b", 32'(busy_b), 32'h1);

    // Release and hammer both ports through the whole clear window.
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = 16'hBEEF;
    wr_be   = 2'b11;
    rd_en   = 1'b1;
    rd_addr = 4'd2;
    n = 0;
    while (busy_a && n < 40) begin
      tick();
      n++;
      $display("clear cycle %0d: busy=%0b rd_valid a/b/c=%0b/%0b/%0b", n, busy_a,
               rd_valid_a, rd_valid_b, rd_valid_c);
      check("clear_rd_valid_a", 32'(rd_valid_a), 32'h0);
      check("clear_rd_valid_c", 32'(rd_valid_c), 32'h0);
    end
    check("clear_busy_cycles", 32'(n), 32'd16);
    check("clear_busy_b_fall", 32'(busy_b), 32'h0);
    check("clear_busy_c_fall", 32'(busy_c), 32'h0);
    idle();

    for (int i = 0; i < NV; i++) begin
      wr_en   = tbl[i].we;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      wr_be   = tbl[i].be;
      rd_en   = tbl[i].re;
      rd_addr = tbl[i].ra;
      tick();
      $display("vec %0d: we=%0b wa=%0d wd=%h be=%b re=%0b ra=%0d -> a=%0b/%h b=%0b/%h c=%0b/%h",
               i, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra,
               rd_valid_a, rd_data_a, rd_valid_b, rd_data_b, rd_valid_c, rd_data_c);
      check($sformatf("vec%0d_valid_a", i), 32'(rd_valid_a), 32'(tbl[i].ev));
      check($sformatf("vec%0d_data_a", i), 32'(rd_data_a), 32'(tbl[i].ea));
      check($sformatf("vec%0d_valid_b", i), 32'(rd_valid_b), 32'(tbl[i].ev));
      check($sformatf("vec%0d_data_b", i), 32'(rd_data_b), 32'(tbl[i].eb));
      pv = (i == 0) ? 1'b0 : tbl[(i == 0) ? 0 : i-1].ev;
      pd = (i == 0) ? 16'h0 : tbl[(i == 0) ? 0 : i-1].ea;
      check($sformatf("vec%0d_valid_c", i), 32'(rd_valid_c), 32'(pv));
      check($sformatf("vec%0d_data_c", i), 32'(rd_data_c), 32'(pd));
    end
    idle();

    // Reset lands while a two-cycle read is still in the pipeline.
    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_data = 16'h5A5A;
    wr_be   = 2'b11;
    tick();
    idle();
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    tick();
    $display("midread launch: a=%0b/%h c=%0b/%h", rd_valid_a, rd_data_a, rd_valid_c, rd_data_c);
    check("midread_valid_a", 32'(rd_valid_a), 32'h1);
    check("midread_data_a", 32'(rd_data_a), 32'h5A5A);
    check("midread_valid_c_early", 32'(rd_valid_c), 32'h0);
    rd_en = 1'b0;
    rst   = 1'b1;
    tick();
    $display("midread reset: c=%0b/%h busy=%0b", rd_valid_c, rd_data_c, busy_c);
    check("midread_valid_c", 32'(rd_valid_c), 32'h0);
    check("midread_data_c", 32'(rd_data_c), 32'h0);
    check("midread_busy_c", 32'(busy_c), 32'h1);
    check("midread_data_a_rst", 32'(rd_data_a), 32'h0);
    tick();
    check("midread_valid_c_hold", 32'(rd_valid_c), 32'h0);
    rst = 1'b0;
    n = 0;
    while (busy_c && n < 40) begin
      tick();
      n++;
      check("reclear_rd_valid_c", 32'(rd_valid_c), 32'h0);
    end
    $display("reclear: busy cycles=%0d", n);
    check("reclear_busy_cycles", 32'(n), 32'd16);

    // The restarted clear must have zeroed the location read before reset.
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    tick();
    idle();
    check("post_clear_valid_c_lat1", 32'(rd_valid_c), 32'h0);
    check("post_clear_data_a", 32'(rd_data_a), 32'h0);
    tick();
    $display("post clear read addr 9: c=%0b/%h", rd_valid_c, rd_data_c);
    check("post_clear_valid_c", 32'(rd_valid_c), 32'h1);
    check("post_clear_data_c", 32'(rd_data_c), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
